// File: rtl/norm_pkg.sv
// Shared definitions for the normalization sequencer: FSM states, chunk
// geometry and width helpers derived from the mantissa width.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } norm_state_e;

  localparam int unsigned CHUNK_W = 16;

  // Number of 16-bit chunks scanned for a mantissa of width w.
  function automatic int unsigned n_chunks(input int unsigned w);
    return w / CHUNK_W;
  endfunction

  // Width of the left-shift amount for a mantissa of width w.
  function automatic int unsigned shift_w(input int unsigned w);
    return $clog2(w);
  endfunction

  // Width of the chunk index (at least one bit).
  function automatic int unsigned chunk_idx_w(input int unsigned w);
    return (n_chunks(w) > 1) ? $clog2(n_chunks(w)) : 1;
  endfunction

endpackage

// File: rtl/LOPD_16bit.sv
// 16-bit leading-one position detector.
// Native convention: scans from bit 0 upward and reports the index of the
// lowest set bit, i.e. the number of zeros below the first one.
//   bits  : 16-bit input vector
//   pos   : index of the lowest set bit (0 when none)
//   found : at least one bit is set
module LOPD_16bit (
  input  logic [15:0] bits,
  output logic [3:0]  pos,
  output logic        found
);

  // Descending loop so the lowest set bit is the last one written.
  always_comb begin
    pos   = 4'd0;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (bits[i]) begin
        pos   = 4'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_scan_seq.sv
// Multi-cycle mantissa normalizer. One shared 16-bit leading-one detector
// scans the mantissa chunk by chunk from the MSB end, then a dedicated cycle
// barrel-shifts the mantissa so its leading one sits at bit W-1 and the
// exponent is reduced by the shift amount.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_valid / o_ready  : input handshake (o_ready high only in IDLE)
//   i_mant, i_exp      : unnormalized mantissa and biased exponent
//   o_valid / i_ready  : result handshake (o_valid held until accepted)
//   o_mant, o_exp      : normalized mantissa, adjusted exponent
//   o_shift            : applied left-shift amount
//   o_zero             : input mantissa was all zero
//   o_uflow            : shift exceeded the input exponent
module norm_scan_seq
  import norm_pkg::*;
#(
  parameter int unsigned W     = 48,
  parameter int unsigned EXP_W = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [W-1:0]          i_mant,
  input  logic [EXP_W-1:0]      i_exp,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [W-1:0]          o_mant,
  output logic [EXP_W-1:0]      o_exp,
  output logic [shift_w(W)-1:0] o_shift,
  output logic                  o_zero,
  output logic                  o_uflow
);

  localparam int unsigned N_CHUNK = n_chunks(W);
  localparam int unsigned SH_W    = shift_w(W);
  localparam int unsigned J_W     = chunk_idx_w(W);

  norm_state_e          state_q;
  logic [W-1:0]         mant_q;
  logic [EXP_W-1:0]     exp_q;
  logic [J_W-1:0]       j_q;
  logic [SH_W-1:0]      shift_q;

  logic [CHUNK_W-1:0]   chunk;
  logic [CHUNK_W-1:0]   chunk_rev;
  logic [3:0]           lz16;
  logic                 lz_found;
  logic [SH_W-1:0]      scan_shift;
  logic                 last_chunk;

  // Chunk mux: chunk 0 is the top 16 bits of the mantissa.
  always_comb begin
    chunk = '0;
    for (int c = 0; c < int'(N_CHUNK); c++) begin
      if (j_q == J_W'(c)) begin
        chunk = mant_q[W-1-CHUNK_W*c -: CHUNK_W];
      end
    end
  end

  // The detector counts from bit 0; reversing the chunk makes its result the
  // number of zeros above the first one counting down from chunk bit 15.
  always_comb begin
    chunk_rev = '0;
    for (int b = 0; b < int'(CHUNK_W); b++) begin
      chunk_rev[b] = chunk[CHUNK_W-1-b];
    end
  end

  LOPD_16bit u_lopd (
    .bits  (chunk_rev),
    .pos   (lz16),
    .found (lz_found)
  );

  // 16*j + lz16 is a plain concatenation since lz16 < 16.
  assign scan_shift = SH_W'({j_q, lz16});
  assign last_chunk = (j_q == J_W'(N_CHUNK - 1));

  // Sequencer with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      j_q     <= '0;
      shift_q <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_mant  <= '0;
      o_exp   <= '0;
      o_shift <= '0;
      o_zero  <= 1'b0;
      o_uflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            mant_q  <= i_mant;
            exp_q   <= i_exp;
            j_q     <= '0;
            o_ready <= 1'b0;
            state_q <= SCAN;
          end
        end

        SCAN: begin
          if (lz_found) begin
            shift_q <= scan_shift;
            state_q <= SHIFT;
          end else if (last_chunk) begin
            // Whole mantissa is zero: report it directly, no shift cycle.
            o_mant  <= '0;
            o_exp   <= '0;
            o_shift <= '0;
            o_zero  <= 1'b1;
            o_uflow <= 1'b0;
            o_valid <= 1'b1;
            state_q <= DONE;
          end else begin
            j_q <= j_q + J_W'(1);
          end
        end

        SHIFT: begin
          o_mant  <= mant_q << shift_q;
          o_exp   <= exp_q - EXP_W'(shift_q);
          o_shift <= shift_q;
          o_zero  <= 1'b0;
          o_uflow <= (EXP_W'(shift_q) > exp_q);
          o_valid <= 1'b1;
          state_q <= DONE;
        end

        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            j_q     <= '0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
